// File: rtl/fetch_stage_pkg.sv
// Shared types for the fetch stage and its decode-side consumer.
// FSM state encoding, reset/step defaults and the registered fetch output record.
package fetch_stage_pkg;

   typedef enum logic [1:0] {
      BOOT,
      REQ,
      WAIT,
      HOLD
   } fetch_state_t;

   localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_0000;
   localparam logic [31:0] PC_STEP_DEFAULT  = 32'd4;

   typedef struct packed {
      logic        valid;
      logic [31:0] pc;
      logic [31:0] instr;
      logic        misalign;
   } fetch_out_t;

   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return addr & 32'hFFFF_FFFC;
   endfunction

endpackage

// File: rtl/fetch_stage_pc_next.sv
// Next-PC selector for the fetch stage: redirect target, sequential step, or hold.
// Redirect always wins over a sequential advance.
module fetch_pc_next #(
   parameter logic [31:0] PC_STEP = 32'd4
) (
   input  logic [31:0] pc_i,
   input  logic        redirect_valid_i,
   input  logic [31:0] redirect_pc_i,
   input  logic        advance_i,
   output logic [31:0] pc_next_o
);

   always_comb begin
      if (redirect_valid_i) begin
         pc_next_o = redirect_pc_i;
      end else if (advance_i) begin
         pc_next_o = pc_i + PC_STEP;
      end else begin
         pc_next_o = pc_i;
      end
   end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, one outstanding imem read, registered output to decode.
// Optional FETCH_MISALIGN_EN turns a misaligned PC into a flagged bubble instead of a fetch.
module fetch_stage
   import fetch_stage_pkg::*;
#(
   parameter logic [31:0] PC_RESET = PC_RESET_DEFAULT,
   parameter logic [31:0] PC_STEP  = PC_STEP_DEFAULT
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req_valid,
   output logic [31:0] imem_req_addr,
   input  logic        imem_req_ready,
   input  logic        imem_resp_valid,
   input  logic [31:0] imem_resp_data,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   input  logic        id_ready,
   output logic        if_valid,
   output logic [31:0] if_pc,
   output logic [31:0] if_instr,
   output logic        if_misalign
);

   fetch_state_t state_q, state_d;
   fetch_out_t   out_q, out_d;
   logic [31:0]  pc_q, pc_d, pc_next;
   logic         drop_q, drop_d;
   logic         advance;
   logic         pc_misaligned;

`ifdef FETCH_MISALIGN_EN
   localparam logic [31:0] PC_RESET_EFF = PC_RESET;
   assign pc_misaligned = |pc_q[1:0];
   assign pc_d          = pc_next;
`else
   // Low PC bits are cleared on every load, so pc_q is always word aligned here.
   localparam logic [31:0] PC_RESET_EFF = word_align(PC_RESET);
   assign pc_misaligned = 1'b0;
   assign pc_d          = word_align(pc_next);
`endif

   fetch_pc_next #(
      .PC_STEP (PC_STEP)
   ) u_pc_next (
      .pc_i             (pc_q),
      .redirect_valid_i (redirect_valid),
      .redirect_pc_i    (redirect_pc),
      .advance_i        (advance),
      .pc_next_o        (pc_next)
   );

   assign imem_req_valid = (state_q == REQ) && !pc_misaligned;
   assign imem_req_addr  = pc_q;

   // NOTE: every comb output gets a default first so no path can infer a latch.
   always_comb begin
      state_d = state_q;
      drop_d  = drop_q;
      out_d   = out_q;
      advance = 1'b0;
      unique case (state_q)
         BOOT: state_d = REQ;
         REQ: begin
            if (pc_misaligned && !redirect_valid) begin
               out_d   = '{valid: 1'b1, pc: pc_q, instr: 32'h0, misalign: 1'b1};
               state_d = HOLD;
            end else if (imem_req_valid && imem_req_ready) begin
               // A redirect in the acceptance cycle lets the request go but poisons its data.
               drop_d  = redirect_valid;
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (imem_resp_valid) begin
               if (drop_q || redirect_valid) begin
                  drop_d  = 1'b0;
                  state_d = REQ;
               end else begin
                  out_d   = '{valid: 1'b1, pc: pc_q, instr: imem_resp_data, misalign: 1'b0};
                  state_d = HOLD;
               end
            end else if (redirect_valid) begin
               drop_d = 1'b1;
            end
         end
         HOLD: begin
            if (redirect_valid || id_ready) begin
               out_d.valid    = 1'b0;
               out_d.misalign = 1'b0;
               advance        = !redirect_valid;
               state_d        = REQ;
            end
         end
         default: state_d = BOOT;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= BOOT;
         pc_q    <= PC_RESET_EFF;
         drop_q  <= 1'b0;
         out_q   <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         drop_q  <= drop_d;
         out_q   <= out_d;
      end
   end

   assign if_valid    = out_q.valid;
   assign if_pc       = out_q.pc;
   assign if_instr    = out_q.instr;
   assign if_misalign = out_q.misalign;

   resp_only_in_wait : assert property (
      @(posedge clk) disable iff (reset) imem_resp_valid |-> (state_q == WAIT)
   ) else $error("imem response arrived while no fetch was outstanding");

endmodule
